rtc_time_core: RTL
==================

# rtc_time_core

Timekeeping core for the real-time clock: divides the 100 MHz board clock to a 1 Hz tick and keeps hours, minutes and seconds as cascaded BCD counters. It selects which four digits to show from the `mode` switch and presents them as a registered 16-bit BCD word. The block sits directly upstream of the seven-segment scan driver that generates the anode and segment outputs.

## Interface
- `TICKS_PER_SEC`, default 100_000_000 — clock cycles per second; minimum 4; the bench uses 10.
- `clk`      in   1   system clock, 100 MHz, all logic on rising edge.
- `reset`    in   1   asynchronous, active-high; clears all state.
- `mode`     in   1   asynchronous switch level; 0 = show mm:ss, 1 = show hh:mm.
- `inc_min`  in   1   synchronous single-cycle pulse; advance minutes by one.
- `inc_hr`   in   1   synchronous single-cycle pulse; advance hours by one.
- `digits`   out  16  BCD, `[15:12]` leftmost digit through `[3:0]` rightmost.
- `sec_tick` out  1   one-cycle pulse, once per second.
- `dp_blink` out  1   colon/decimal-point blink, 1 Hz with 50 % duty.

## Operation
- Prescaler `pcnt` counts 0..TICKS_PER_SEC-1, then wraps to 0. Condition `wrap` = (`pcnt` == TICKS_PER_SEC-1).
- On the `wrap` edge, seconds advance and carries propagate in the same edge:
  - s1 9→0 carries into s10;
  - s10:s1 59→00 carries into minutes;
  - minutes 59→00 carries into hours;
  - hours 23→00 in the default 24 h format.
- `inc_min`:
  - minutes +1, wrapping 59→00 with no carry into hours;
  - seconds and prescaler are unaffected;
  - if the same edge also produces a seconds→minutes carry, minutes advance by exactly 1 and the extra carry is discarded.
- `inc_hr`: hours +1 with the format's wrap; an hours carry on the same edge is absorbed the same way, so the total step is 1.
- `mode` passes through a 2-flop synchronizer (`mode_s`).
- `digits` register:
  - `mode_s`=0 → {m10,m1,s10,s1};
  - `mode_s`=1 → {h10,h1,m10,m1}.
- `dp_blink` = registered (`pcnt` < TICKS_PER_SEC/2).
- All BCD digits stay legal at all times: tens 0..5 for seconds and minutes; hours 00..23 in 24 h format.

## Timing
- Reset values:
  - `pcnt`=0, `sec_tick`=0, `dp_blink`=0, `mode_s`=0;
  - time 00:00:00 in 24 h format;
  - `digits`=16'h0000.
- Reset takes effect immediately, including mid-count or mid-carry; there is no partial carry after release.
- `sec_tick` is high during the cycle following every `wrap` edge. The first pulse comes after the TICKS_PER_SEC-th rising edge after reset release, then one pulse every TICKS_PER_SEC cycles.
- Time registers update on the `wrap` edge. `digits` reflects the new time one edge later, i.e. in the same cycle `sec_tick` is high plus one.
- `mode` change → `digits` reselected after 3 rising edges (2 synchronizer + 1 output register).
- `inc_min`/`inc_hr` sampled at edge k → `digits` updated after edge k+1.
- `inc_*` pulses held high for several cycles advance the field once per cycle; debouncing and edge detection are upstream responsibilities.

## Configuration
- `RTC_12H_EN` defined:
  - hours run 12-hour format, sequence 12→01→…→11→12;
  - reset time is 12:00:00;
  - hour digits show 1..12, with h10 either 0 or 1.
- `RTC_12H_EN` undefined: 24 h format, 00..23, reset time 00:00:00.
- No AM/PM indicator in either build. Minutes and seconds behaviour is identical in both.

## Test plan
- TICKS_PER_SEC=10, reset 100 ns then release, `mode`=0 → `sec_tick` pulses every 10 cycles; `digits`=16'h0001 after the first tick, 16'h0010 after 10 ticks.
- Force time to 23:59:59 using `inc_hr`/`inc_min` plus ticks, `mode`=1, one tick → time 00:00:00 and `digits`=16'h0000; with `RTC_12H_EN`, 12:59:59 → 01:00:00 and `digits`=16'h0100.
- `inc_min` asserted on the same edge as a 59→00 seconds carry, from 10:05:59 → minutes become 06, not 07; seconds become 00.
- `mode` toggled 0→1 at 10:05:xx → `digits` changes from 16'h05xx to 16'h1005 exactly 3 edges later.
- `reset` asserted mid-second at time 00:45:30 → all outputs return to reset values asynchronously; the first `sec_tick` after release follows 10 edges later.
- `dp_blink` over one second → high for 5 cycles, low for 5 cycles, aligned to the `pcnt` wrap.

Source files
------------

// File: rtl/rtc_time_core.sv
// Real-time clock core: 1 Hz prescaler, cascaded BCD hh:mm:ss counters and a
// mode-selected registered 4-digit BCD display word. Define RTC_12H_EN for 12-hour format.
module rtc_time_core #(
    parameter int unsigned TICKS_PER_SEC = 100_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mode,
    input  logic        inc_min,
    input  logic        inc_hr,
    output logic [15:0] digits,
    output logic        sec_tick,
    output logic        dp_blink
);

    localparam int unsigned PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] PCNT_MAX  = PW'(TICKS_PER_SEC - 1);
    localparam logic [PW-1:0] PCNT_HALF = PW'(TICKS_PER_SEC / 2);
`ifdef RTC_12H_EN
    localparam logic [3:0] H10_RST = 4'd1;
    localparam logic [3:0] H1_RST  = 4'd2;
`else
    localparam logic [3:0] H10_RST = 4'd0;
    localparam logic [3:0] H1_RST  = 4'd0;
`endif

    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [3:0]    s1_q, s1_d, s10_q, s10_d;
    logic [3:0]    m1_q, m1_d, m10_q, m10_d;
    logic [3:0]    h1_q, h1_d, h10_q, h10_d;
    logic          mode_meta_q, mode_s_q;
    logic [15:0]   digits_q, digits_d;
    logic          sec_tick_q, sec_tick_d;
    logic          dp_blink_q, dp_blink_d;
    logic          wrap, sec_carry, hr_carry;

    // Next-state: prescaler, carry chain and display selection
    always_comb begin
        pcnt_d     = pcnt_q;
        s1_d       = s1_q;
        s10_d      = s10_q;
        m1_d       = m1_q;
        m10_d      = m10_q;
        h1_d       = h1_q;
        h10_d      = h10_q;

        wrap       = (pcnt_q == PCNT_MAX);
        sec_carry  = wrap && (s10_q == 4'd5) && (s1_q == 4'd9);
        // A coincident inc_min only collapses the minute step; the rollover still carries
        hr_carry   = sec_carry && (m10_q == 4'd5) && (m1_q == 4'd9);

        pcnt_d     = wrap ? '0 : pcnt_q + PW'(1);

        if (wrap) begin
            if (s1_q == 4'd9) begin
                s1_d  = 4'd0;
                s10_d = (s10_q == 4'd5) ? 4'd0 : s10_q + 4'd1;
            end else begin
                s1_d  = s1_q + 4'd1;
            end
        end

        if (sec_carry || inc_min) begin
            if (m1_q == 4'd9) begin
                m1_d  = 4'd0;
                m10_d = (m10_q == 4'd5) ? 4'd0 : m10_q + 4'd1;
            end else begin
                m1_d  = m1_q + 4'd1;
            end
        end

        if (hr_carry || inc_hr) begin
`ifdef RTC_12H_EN
            if (h10_q == 4'd1 && h1_q == 4'd2) begin
                h10_d = 4'd0;
                h1_d  = 4'd1;
            end
`else
            if (h10_q == 4'd2 && h1_q == 4'd3) begin
                h10_d = 4'd0;
                h1_d  = 4'd0;
            end
`endif
            else if (h1_q == 4'd9) begin
                h10_d = h10_q + 4'd1;
                h1_d  = 4'd0;
            end else begin
                h1_d  = h1_q + 4'd1;
            end
        end

        digits_d   = mode_s_q ? {h10_q, h1_q, m10_q, m1_q} : {m10_q, m1_q, s10_q, s1_q};
        sec_tick_d = wrap;
        dp_blink_d = (pcnt_q < PCNT_HALF);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt_q      <= '0;
            s1_q        <= 4'd0;
            s10_q       <= 4'd0;
            m1_q        <= 4'd0;
            m10_q       <= 4'd0;
            h1_q        <= H1_RST;
            h10_q       <= H10_RST;
            mode_meta_q <= 1'b0;
            mode_s_q    <= 1'b0;
            digits_q    <= 16'h0000;
            sec_tick_q  <= 1'b0;
            dp_blink_q  <= 1'b0;
        end else begin
            pcnt_q      <= pcnt_d;
            s1_q        <= s1_d;
            s10_q       <= s10_d;
            m1_q        <= m1_d;
            m10_q       <= m10_d;
            h1_q        <= h1_d;
            h10_q       <= h10_d;
            mode_meta_q <= mode;
            mode_s_q    <= mode_meta_q;
            digits_q    <= digits_d;
            sec_tick_q  <= sec_tick_d;
            dp_blink_q  <= dp_blink_d;
        end
    end

    assign digits   = digits_q;
    assign sec_tick = sec_tick_q;
    assign dp_blink = dp_blink_q;

endmodule
